// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and branch predictor types.
package riscv_pkg;

    // Major opcodes recognised by the fetch-stage predictor
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Encoding of the pred_kind output
    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_BR   = 2'b01,
        KIND_JAL  = 2'b10,
        KIND_JALR = 2'b11
    } pred_kind_e;

    // Two-bit saturating counter states; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Predictor control state
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } bp_state_e;

    // Saturating step of a 2-bit counter towards the resolved outcome
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        case (ctr)
            CTR_SNT: res = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: res = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  res = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  res = taken ? CTR_ST  : CTR_WT;
            default: res = CTR_WNT;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_decode.sv
// Combinational RV32 control-flow decode: kind, ECALL flag and static target.
module branch_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output pred_kind_e      kind,
    output logic            is_ecall,
    output logic [XLEN-1:0] target
);

    logic [XLEN-1:0] b_imm_s;
    logic [XLEN-1:0] j_imm_s;
    logic [XLEN-1:0] four_s;

    assign b_imm_s = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign j_imm_s = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign four_s  = {{(XLEN-3){1'b0}}, 3'b100};

    // Classify the opcode and pick the fall-through or PC-relative target
    always_comb begin
        kind     = KIND_NONE;
        is_ecall = 1'b0;
        target   = pc + four_s;
        case (instr[6:0])
            OP_BRANCH: begin
                kind   = KIND_BR;
                target = pc + b_imm_s;
            end
            OP_JAL: begin
                kind   = KIND_JAL;
                target = pc + j_imm_s;
            end
            OP_JALR: begin
                kind = KIND_JALR;
            end
            OP_SYSTEM: begin
                is_ecall = 1'b1;
            end
            default: begin
                kind = KIND_NONE;
            end
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: bimodal 2-bit counter table, RUN/HALT control
// around ECALL, and a saturating mispredict counter.
module branch_predictor
    import riscv_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 16,
    parameter logic [1:0] CTR_INIT    = 2'b01,
    parameter int         MISS_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [31:0]       if_instr,
    input  logic              flush,
    input  logic              ecall_done,
    output logic              pred_valid,
    output logic [1:0]        pred_kind,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    output logic              pred_ecall,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_taken,
    output logic [MISS_W-1:0] miss_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bp_state_e         state_r;
    bp_state_e         state_next_s;
    logic [1:0]        bht_r [BHT_ENTRIES];
    logic [IDX_W-1:0]  if_idx_s;
    logic [IDX_W-1:0]  ex_idx_s;
    logic [1:0]        lookup_ctr_s;
    logic [1:0]        ex_ctr_s;
    pred_kind_e        kind_s;
    logic              is_ecall_s;
    logic [XLEN-1:0]   target_s;
    logic              taken_s;
    logic              fire_s;
    logic              mispredict_s;
    logic              pred_valid_r;
    logic [1:0]        pred_kind_r;
    logic              pred_taken_r;
    logic [XLEN-1:0]   pred_target_r;
    logic              pred_ecall_r;
    logic [MISS_W-1:0] miss_count_r;
    logic              pc_unused_s;

    // Only the word-index bits of the PCs address the table
    assign if_idx_s    = if_pc[IDX_W+1:2];
    assign ex_idx_s    = ex_pc[IDX_W+1:2];
    assign pc_unused_s = ^{ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    assign lookup_ctr_s = bht_r[if_idx_s];
    assign ex_ctr_s     = bht_r[ex_idx_s];
    assign fire_s       = if_valid & (state_r == ST_RUN);
    assign mispredict_s = ex_valid & (ex_taken != ex_ctr_s[1]);

    branch_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr    (if_instr),
        .pc       (if_pc),
        .kind     (kind_s),
        .is_ecall (is_ecall_s),
        .target   (target_s)
    );

    // Direction: conditional branches follow the counter (pre-update value), JAL always redirects
    always_comb begin
        taken_s = 1'b0;
        case (kind_s)
            KIND_BR:  taken_s = lookup_ctr_s[1];
            KIND_JAL: taken_s = 1'b1;
            default:  taken_s = 1'b0;
        endcase
    end

    // Next-state logic: an accepted, unflushed ECALL halts fetch until serviced
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (fire_s && is_ecall_s && !flush) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (ecall_done) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Counter table training from resolved branches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= CTR_INIT;
            end
        end else if (ex_valid) begin
            bht_r[ex_idx_s] <= ctr_next(ex_ctr_s, ex_taken);
        end
    end

    // Saturating mispredict statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_count_r <= {MISS_W{1'b0}};
        end else if (mispredict_s && (miss_count_r != {MISS_W{1'b1}})) begin
            miss_count_r <= miss_count_r + {{(MISS_W-1){1'b0}}, 1'b1};
        end
    end

    // Prediction register: flush kills, accepted fetch loads, otherwise valid/ecall drop and payload holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_valid_r  <= 1'b0;
            pred_kind_r   <= KIND_NONE;
            pred_taken_r  <= 1'b0;
            pred_target_r <= {XLEN{1'b0}};
            pred_ecall_r  <= 1'b0;
        end else if (flush) begin
            pred_valid_r <= 1'b0;
            pred_ecall_r <= 1'b0;
        end else if (fire_s) begin
            pred_valid_r  <= 1'b1;
            pred_kind_r   <= kind_s;
            pred_taken_r  <= taken_s;
            pred_target_r <= target_s;
            pred_ecall_r  <= is_ecall_s;
        end else begin
            pred_valid_r <= 1'b0;
            pred_ecall_r <= 1'b0;
        end
    end

    assign if_ready    = (state_r == ST_RUN);
    assign pred_valid  = pred_valid_r;
    assign pred_kind   = pred_kind_r;
    assign pred_taken  = pred_taken_r;
    assign pred_target = pred_target_r;
    assign pred_ecall  = pred_ecall_r;
    assign miss_count  = miss_count_r;

endmodule
